// File: rtl/pll_reset_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        DEBOUNCE   = 2'd1,
        STAGGER_ST = 2'd2,
        RUN        = 2'd3
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;

    // Counter must hold the larger of the two terminal counts.
    function automatic int cnt_width(input int debounce, input int stagger);
        int max_cnt;
        max_cnt = (debounce > stagger) ? debounce : stagger;
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock input and staged reset outputs between the PLL wrapper side and design tops.
interface pll_reset_sequencer_if;
    import pll_reset_seq_pkg::*;

    logic                  pll_lock;
    logic                  rst_core_n;
    logic                  rst_periph_n;
    logic                  ready;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] lock_loss_count;

    modport master (
        input  pll_lock,
        output rst_core_n,
        output rst_periph_n,
        output ready,
        output lock_lost,
        output lock_loss_count
    );

    modport slave (
        output pll_lock,
        input  rst_core_n,
        input  rst_periph_n,
        input  ready,
        input  lock_lost,
        input  lock_loss_count
    );

endinterface

// File: rtl/sync_nff.sv
// N-stage single-bit synchronizer, asynchronously cleared to 0.
module sync_nff #(
    parameter int N = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    // NOTE: sequential state is always written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns raw PLL lock into staged core/peripheral resets and a ready flag.
// Define PLL_RESET_SEQ_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_DEBOUNCE = 1024,
    parameter int STAGGER       = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pll_reset_sequencer_if.master seq
);

    localparam int CW = cnt_width(LOCK_DEBOUNCE, STAGGER);
    // Terminal values are one less than the lengths: the edge that reaches them also leaves the state.
    localparam logic [CW-1:0] DEB_TRIG = CW'(LOCK_DEBOUNCE - 1);
    localparam logic [CW-1:0] STG_TRIG = CW'(STAGGER - 1);

    logic          lock_s;
    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          loss;

    sync_nff #(.N(SYNC_STAGES)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (seq.pll_lock),
        .q       (lock_s)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CW'(1);
                end
            end
            DEBOUNCE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_TRIG) begin
                    state_d = STAGGER_ST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STAGGER_ST: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss    = 1'b1;
                end else if (cnt_q >= STG_TRIG) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss    = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= WAIT_LOCK;
            cnt_q            <= '0;
            seq.rst_core_n   <= 1'b0;
            seq.rst_periph_n <= 1'b0;
            seq.ready        <= 1'b0;
            seq.lock_lost    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            seq.rst_core_n   <= (state_d == STAGGER_ST) || (state_d == RUN);
            seq.rst_periph_n <= (state_d == RUN);
            seq.ready        <= (state_d == RUN);
            seq.lock_lost    <= loss;
        end
    end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt_q <= '0;
        end else if (loss && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign seq.lock_loss_count = loss_cnt_q;
`else
    assign seq.lock_loss_count = '0;
`endif

endmodule
